// File: rtl/rv32i_multicycle_control.sv
// Main control sequencer for the multi-cycle RV32I core.
// Walks fetch/decode/execute/memory/writeback, handshakes with the shared memory
// port, resolves branches from ALU flags and traps on illegal encodings or memory timeouts.
module rv32i_multicycle_control #(
   parameter int unsigned ALU_CTRL_W  = 4,
   parameter int unsigned MEM_TIMEOUT = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [31:0]           i_instr,
   input  logic                  i_mem_ready,
   input  logic                  i_alu_zero,
   input  logic                  i_alu_lsb,
   output logic                  o_mem_req,
   output logic                  o_mem_we,
   output logic                  o_ir_write,
   output logic                  o_pc_write,
   output logic                  o_pc_src,
   output logic                  o_reg_write,
   output logic [1:0]            o_wb_sel,
   output logic [1:0]            o_alu_src_a,
   output logic [1:0]            o_alu_src_b,
   output logic [2:0]            o_imm_sel,
   output logic [ALU_CTRL_W-1:0] o_alu_control,
   output logic                  o_illegal,
   output logic                  o_bus_err,
   output logic [2:0]            o_state
);

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StTrap   = 3'd5
   } state_e;

   localparam logic [6:0] OpOp     = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;

   localparam logic [3:0] AluAdd  = 4'b0000;
   localparam logic [3:0] AluSub  = 4'b1000;
   localparam logic [3:0] AluSlt  = 4'b0010;
   localparam logic [3:0] AluSltu = 4'b0011;

   state_e      r_state;
   state_e      w_state_d;
   logic [31:0] r_wait_cnt;
   logic        r_illegal;
   logic        r_bus_err;

   logic [6:0]  w_opcode;
   logic [2:0]  w_func3;
   logic [6:0]  w_func7;
   logic        w_legal;
   logic        w_timeout;
   logic        w_taken;
   logic        w_set_illegal;
   logic        w_set_bus_err;
   logic [3:0]  w_alu_op;
   logic [3:0]  w_op_alu;
   logic [3:0]  w_opimm_alu;
   logic [3:0]  w_branch_alu;
   logic        w_unused;

   assign w_opcode = i_instr[6:0];
   assign w_func3  = i_instr[14:12];
   assign w_func7  = i_instr[31:25];
   // Register indices and immediate bits are consumed by the datapath, not here.
   assign w_unused = ^{i_instr[24:15], i_instr[11:7]};

   // instr[30] selects SUB/SRA for OP, but only SRAI for OP-IMM (ADDI never subtracts).
   assign w_op_alu    = {i_instr[30] & (w_func3 == 3'b000 || w_func3 == 3'b101), w_func3};
   assign w_opimm_alu = {i_instr[30] & (w_func3 == 3'b101), w_func3};
   assign w_branch_alu = (w_func3[2] == 1'b0) ? AluSub :
                         (w_func3[1] == 1'b0) ? AluSlt : AluSltu;
   // func3[0] inverts the sense: BNE/BGE/BGEU.
   assign w_taken = ((w_func3[2]) ? i_alu_lsb : i_alu_zero) ^ w_func3[0];

   // The limit cycle only trips when mem_ready is absent in that same cycle.
   assign w_timeout = (MEM_TIMEOUT > 0) && (r_wait_cnt == MEM_TIMEOUT - 1);

   assign o_alu_control = ALU_CTRL_W'(w_alu_op);
   assign o_illegal     = r_illegal;
   assign o_bus_err     = r_bus_err;
   assign o_state       = r_state;

   // Legality check of the instruction register against the supported RV32I subset.
   always_comb begin
      w_legal = 1'b0;
      case (w_opcode)
         OpOp:     w_legal = (w_func7 == 7'h00) ||
                             (w_func7 == 7'h20 && (w_func3 == 3'b000 || w_func3 == 3'b101));
         OpImm: begin
            if (w_func3 == 3'b001) begin
               w_legal = (w_func7 == 7'h00);
            end else if (w_func3 == 3'b101) begin
               w_legal = (w_func7 == 7'h00) || (w_func7 == 7'h20);
            end else begin
               w_legal = 1'b1;
            end
         end
         OpLui, OpAuipc, OpJal: w_legal = 1'b1;
         OpJalr:   w_legal = (w_func3 == 3'b000);
         OpBranch: w_legal = (w_func3 != 3'b010) && (w_func3 != 3'b011);
         OpLoad:   w_legal = w_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
         OpStore:  w_legal = (w_func3 <= 3'b010);
         default:  w_legal = 1'b0;
      endcase
   end

   // Next-state and datapath control decode.
   always_comb begin
      w_state_d     = r_state;
      o_mem_req     = 1'b0;
      o_mem_we      = 1'b0;
      o_ir_write    = 1'b0;
      o_pc_write    = 1'b0;
      o_pc_src      = 1'b0;
      o_reg_write   = 1'b0;
      o_wb_sel      = 2'd0;
      o_alu_src_a   = 2'd0;
      o_alu_src_b   = 2'd0;
      o_imm_sel     = 3'd0;
      w_alu_op      = AluAdd;
      w_set_illegal = 1'b0;
      w_set_bus_err = 1'b0;
      unique case (r_state)
         StFetch: begin
            o_mem_req   = 1'b1;
            o_alu_src_a = 2'd1;
            o_alu_src_b = 2'd2;
            if (i_mem_ready) begin
               o_ir_write = 1'b1;
               o_pc_write = 1'b1;
               w_state_d  = StDecode;
            end else if (w_timeout) begin
               w_set_bus_err = 1'b1;
               w_state_d     = StTrap;
            end
         end
         StDecode: begin
            // Branch/jump target lands in alu_out for use in EXEC.
            o_alu_src_a = 2'd2;
            o_alu_src_b = 2'd1;
            if (w_opcode == OpBranch) begin
               o_imm_sel = 3'd2;
            end else if (w_opcode == OpJal) begin
               o_imm_sel = 3'd4;
            end
            if (!w_legal) begin
               w_set_illegal = 1'b1;
               w_state_d     = StTrap;
            end else begin
               w_state_d = StExec;
            end
         end
         StExec: begin
            case (w_opcode)
               OpOp: begin
                  w_alu_op  = w_op_alu;
                  w_state_d = StWb;
               end
               OpImm: begin
                  o_alu_src_b = 2'd1;
                  w_alu_op    = w_opimm_alu;
                  w_state_d   = StWb;
               end
               OpLui: begin
                  o_alu_src_a = 2'd3;
                  o_alu_src_b = 2'd1;
                  o_imm_sel   = 3'd3;
                  w_state_d   = StWb;
               end
               OpAuipc: begin
                  o_alu_src_a = 2'd2;
                  o_alu_src_b = 2'd1;
                  o_imm_sel   = 3'd3;
                  w_state_d   = StWb;
               end
               OpLoad, OpStore: begin
                  o_alu_src_b = 2'd1;
                  o_imm_sel   = (w_opcode == OpStore) ? 3'd1 : 3'd0;
                  w_state_d   = StMem;
               end
               OpBranch: begin
                  w_alu_op   = w_branch_alu;
                  o_pc_write = w_taken;
                  o_pc_src   = w_taken;
                  w_state_d  = StFetch;
               end
               OpJal: begin
                  o_pc_write  = 1'b1;
                  o_pc_src    = 1'b1;
                  o_reg_write = 1'b1;
                  o_wb_sel    = 2'd2;
                  w_state_d   = StFetch;
               end
               OpJalr: begin
                  o_alu_src_b = 2'd1;
                  o_pc_write  = 1'b1;
                  o_reg_write = 1'b1;
                  o_wb_sel    = 2'd2;
                  w_state_d   = StFetch;
               end
               default: w_state_d = StFetch;
            endcase
         end
         StMem: begin
            o_mem_req = 1'b1;
            o_mem_we  = (w_opcode == OpStore);
            if (i_mem_ready) begin
               w_state_d = (w_opcode == OpStore) ? StFetch : StWb;
            end else if (w_timeout) begin
               w_set_bus_err = 1'b1;
               w_state_d     = StTrap;
            end
         end
         StWb: begin
            o_reg_write = 1'b1;
            o_wb_sel    = (w_opcode == OpLoad) ? 2'd1 : 2'd0;
            w_state_d   = StFetch;
         end
         StTrap:  w_state_d = StTrap;
         default: w_state_d = StFetch;
      endcase
   end

   // State register and sticky trap flags.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= StFetch;
         r_illegal <= 1'b0;
         r_bus_err <= 1'b0;
      end else begin
         r_state <= w_state_d;
         if (w_set_illegal) begin
            r_illegal <= 1'b1;
         end
         if (w_set_bus_err) begin
            r_bus_err <= 1'b1;
         end
      end
   end

   // Wait counter: restarts on every state change, counts cycles spent stalled in FETCH/MEM.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wait_cnt <= 32'd0;
      end else if (w_state_d != r_state) begin
         r_wait_cnt <= 32'd0;
      end else if ((MEM_TIMEOUT > 0) && (r_state == StFetch || r_state == StMem)) begin
         r_wait_cnt <= r_wait_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_rv32i_multicycle_control.sv
// Self-checking bench for rv32i_multicycle_control: directed cases plus random
// instruction streams, compared cycle by cycle against an instruction-level model.
module tb_rv32i_multicycle_control;

   localparam int TO = 4;

   localparam int KR = 0, KI = 1, KLui = 2, KAuipc = 3, KLoad = 4, KStore = 5,
                  KBr = 6, KJal = 7, KJalr = 8, KBad = 9;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       ir_write;
      logic       pc_write;
      logic       pc_src;
      logic       reg_write;
      logic [1:0] wb_sel;
      logic [1:0] src_a;
      logic [1:0] src_b;
      logic [2:0] imm_sel;
      logic [5:0] alu;
      logic       illegal;
      logic       bus_err;
      logic [2:0] state;
   } outs_t;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [31:0] i_instr = 32'd0;
   logic        i_mem_ready = 1'b0;
   logic        i_alu_zero = 1'b0;
   logic        i_alu_lsb = 1'b0;
   logic        o_mem_req, o_mem_we, o_ir_write, o_pc_write, o_pc_src, o_reg_write;
   logic [1:0]  o_wb_sel, o_alu_src_a, o_alu_src_b;
   logic [2:0]  o_imm_sel;
   logic [5:0]  o_alu_control;
   logic        o_illegal, o_bus_err;
   logic [2:0]  o_state;
   outs_t       obs;

   int n_tests = 0;
   int n_fail  = 0;

   rv32i_multicycle_control #(
      .ALU_CTRL_W (6),
      .MEM_TIMEOUT(TO)
   ) dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_instr      (i_instr),
      .i_mem_ready  (i_mem_ready),
      .i_alu_zero   (i_alu_zero),
      .i_alu_lsb    (i_alu_lsb),
      .o_mem_req    (o_mem_req),
      .o_mem_we     (o_mem_we),
      .o_ir_write   (o_ir_write),
      .o_pc_write   (o_pc_write),
      .o_pc_src     (o_pc_src),
      .o_reg_write  (o_reg_write),
      .o_wb_sel     (o_wb_sel),
      .o_alu_src_a  (o_alu_src_a),
      .o_alu_src_b  (o_alu_src_b),
      .o_imm_sel    (o_imm_sel),
      .o_alu_control(o_alu_control),
      .o_illegal    (o_illegal),
      .o_bus_err    (o_bus_err),
      .o_state      (o_state)
   );

   always #5 clk = ~clk;

   assign obs = {o_mem_req, o_mem_we, o_ir_write, o_pc_write, o_pc_src, o_reg_write,
                 o_wb_sel, o_alu_src_a, o_alu_src_b, o_imm_sel, o_alu_control,
                 o_illegal, o_bus_err, o_state};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Instruction class by mnemonic table; anything not listed is illegal.
   function automatic int kind_of(input logic [31:0] ins);
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = ins[14:12];
      f7 = ins[31:25];
      case (ins[6:0])
         7'h33: begin
            if (f7 == 7'h00) return KR;                            // ADD..AND
            if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return KR; // SUB, SRA
            return KBad;
         end
         7'h13: begin
            if (f3 == 3'd1) return (f7 == 7'h00) ? KI : KBad;      // SLLI
            if (f3 == 3'd5) return (f7 == 7'h00 || f7 == 7'h20) ? KI : KBad;
            return KI;
         end
         7'h37: return KLui;
         7'h17: return KAuipc;
         7'h6F: return KJal;
         7'h67: return (f3 == 3'd0) ? KJalr : KBad;
         7'h63: return (f3 == 3'd2 || f3 == 3'd3) ? KBad : KBr;
         7'h03: return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5)
                       ? KLoad : KBad;
         7'h23: return (f3 <= 3'd2) ? KStore : KBad;
         default: return KBad;
      endcase
   endfunction

   function automatic logic [3:0] exp_alu(input logic [31:0] ins, input int k);
      logic [2:0] f3;
      f3 = ins[14:12];
      if (k == KR) return (ins[31:25] == 7'h20) ? {1'b1, f3} : {1'b0, f3};
      if (k == KI) return (f3 == 3'd5 && ins[31:25] == 7'h20) ? 4'b1101 : {1'b0, f3};
      if (k == KBr) begin
         if (f3 == 3'd0 || f3 == 3'd1) return 4'b1000;
         if (f3 == 3'd4 || f3 == 3'd5) return 4'b0010;
         return 4'b0011;
      end
      return 4'b0000;
   endfunction

   function automatic logic br_taken(input logic [2:0] f3, input logic z, input logic l);
      case (f3)
         3'd0:    return z;
         3'd1:    return !z;
         3'd4:    return l;
         3'd5:    return !l;
         3'd6:    return l;
         default: return !l;
      endcase
   endfunction

   function automatic outs_t quiet(input logic [2:0] st);
      outs_t e;
      e = '0;
      e.state = st;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 10))
         0: r[6:0] = 7'h33;
         1: r[6:0] = 7'h13;
         2: r[6:0] = 7'h37;
         3: r[6:0] = 7'h17;
         4: r[6:0] = 7'h6F;
         5: r[6:0] = 7'h67;
         6: r[6:0] = 7'h63;
         7: r[6:0] = 7'h03;
         8: r[6:0] = 7'h23;
         9: r[6:0] = 7'h33;
         default: ;
      endcase
      if ($urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      return r;
   endfunction

   // Entered and left at posedge+1; outputs compared at the following negedge.
   task automatic step(input logic rdy, input outs_t exp, input string tag);
      i_mem_ready = rdy;
      @(negedge clk);
      check(tag, {6'd0, obs}, {6'd0, exp});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      @(posedge clk);
      #1;
      i_rst = 1'b0;
   endtask

   task automatic trap_seq(input logic is_illegal, input string tag);
      outs_t e;
      e = quiet(3'd5);
      e.illegal = is_illegal;
      e.bus_err = !is_illegal;
      for (int c = 0; c < 2; c++) step(1'($urandom), e, {tag, "/trap"});
      do_reset();
   endtask

   // One instruction: fw FETCH wait cycles, mw MEM wait cycles; waits >= TO must trap.
   task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input logic z,
                            input logic l, input string tag);
      int    k;
      outs_t e;
      logic  tk;
      k = kind_of(ins);
      i_instr = ins;
      i_alu_zero = z;
      i_alu_lsb = l;

      e = quiet(3'd0);
      e.mem_req = 1'b1;
      e.src_a = 2'd1;
      e.src_b = 2'd2;
      for (int c = 0; c < fw && c < TO; c++) step(1'b0, e, {tag, "/fetch_wait"});
      if (fw >= TO) begin
         trap_seq(1'b0, tag);
         return;
      end
      e.ir_write = 1'b1;
      e.pc_write = 1'b1;
      step(1'b1, e, {tag, "/fetch"});

      e = quiet(3'd1);
      e.src_a = 2'd2;
      e.src_b = 2'd1;
      e.imm_sel = (k == KBr) ? 3'd2 : (k == KJal) ? 3'd4 : 3'd0;
      if (ins[6:0] == 7'h63 && k == KBad) e.imm_sel = 3'd2;
      step(1'($urandom), e, {tag, "/decode"});
      if (k == KBad) begin
         trap_seq(1'b1, tag);
         return;
      end

      e = quiet(3'd2);
      e.alu = {2'b00, exp_alu(ins, k)};
      case (k)
         KR: ;
         KI: e.src_b = 2'd1;
         KLui: begin e.src_a = 2'd3; e.src_b = 2'd1; e.imm_sel = 3'd3; end
         KAuipc: begin e.src_a = 2'd2; e.src_b = 2'd1; e.imm_sel = 3'd3; end
         KLoad: e.src_b = 2'd1;
         KStore: begin e.src_b = 2'd1; e.imm_sel = 3'd1; end
         KBr: begin
            tk = br_taken(ins[14:12], z, l);
            e.pc_write = tk;
            e.pc_src = tk;
         end
         KJal: begin e.pc_write = 1; e.pc_src = 1; e.reg_write = 1; e.wb_sel = 2'd2; end
         default: begin e.src_b = 2'd1; e.pc_write = 1; e.reg_write = 1; e.wb_sel = 2'd2; end
      endcase
      step(1'($urandom), e, {tag, "/exec"});
      if (k == KBr || k == KJal || k == KJalr) return;

      if (k == KLoad || k == KStore) begin
         e = quiet(3'd3);
         e.mem_req = 1'b1;
         e.mem_we = (k == KStore);
         for (int c = 0; c < mw && c < TO; c++) step(1'b0, e, {tag, "/mem_wait"});
         if (mw >= TO) begin
            trap_seq(1'b0, tag);
            return;
         end
         step(1'b1, e, {tag, "/mem"});
         if (k == KStore) return;
      end

      e = quiet(3'd4);
      e.reg_write = 1'b1;
      e.wb_sel = (k == KLoad) ? 2'd1 : 2'd0;
      step(1'($urandom), e, {tag, "/wb"});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] r;
      repeat (2) @(posedge clk);
      #1;
      i_rst = 1'b0;

      run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, "add");
      run_instr(32'h402081B3, 0, 0, 1'b0, 1'b0, "sub");
      run_instr(32'h4020D193, 0, 0, 1'b0, 1'b0, "srai");
      run_instr(32'h40008193, 0, 0, 1'b0, 1'b0, "addi_b30");
      run_instr(32'h00208063, 0, 0, 1'b1, 1'b0, "beq_taken");
      run_instr(32'h00208063, 0, 0, 1'b0, 1'b1, "beq_not");
      run_instr(32'h0000A183, 0, 3, 1'b0, 1'b0, "lw_wait");
      run_instr(32'h0020A223, 1, 2, 1'b0, 1'b0, "sw");
      run_instr(32'h008000EF, 0, 0, 1'b0, 1'b0, "jal");
      run_instr(32'h000080E7, 0, 0, 1'b0, 1'b0, "jalr");
      run_instr(32'h123450B7, 0, 0, 1'b0, 1'b0, "lui");
      run_instr(32'h12345097, 0, 0, 1'b0, 1'b0, "auipc");
      run_instr(32'h0000007F, 0, 0, 1'b0, 1'b0, "bad_opc");
      run_instr(32'h022081B3, 0, 0, 1'b0, 1'b0, "bad_f7");
      run_instr(32'h002081B3, TO, 0, 1'b0, 1'b0, "fetch_to");
      run_instr(32'h002081B3, TO - 1, 0, 1'b0, 1'b0, "fetch_last");
      run_instr(32'h0000A183, 0, TO, 1'b0, 1'b0, "mem_to");
      run_instr(32'h0000A183, 0, TO - 1, 1'b0, 1'b0, "mem_last");

      for (int n = 0; n < 300; n++) begin
         r = rand_instr();
         run_instr(r, $urandom_range(0, TO - 1), $urandom_range(0, TO - 1),
                   1'($urandom), 1'($urandom), $sformatf("rnd%0d_%h", n, r));
      end
      run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, "final_add");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/rv32i_multicycle_control.md
# rv32i_multicycle_control

Main control FSM for the multi-cycle RV32I core, generalising the combinational opcode/func3 ALU decoder into a sequencer. It drives the fetch, decode, execute, memory and writeback phases, handshakes with the shared instruction/data memory port, and resolves branches from ALU flags. It decodes the full RV32I base set (no FENCE/SYSTEM) and traps on illegal encodings instead of reporting them only in simulation. It sits between the instruction register and the datapath muxes and write enables.

## Interface
- ALU_CTRL_W, 4: alu_control width, ≥4; bits above [3] driven 0.
- MEM_TIMEOUT, 0: cycles a memory request may wait before bus_err; 0 disables the timeout.

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- instr  in  32  instruction register contents
- mem_ready  in  1  memory completes the request this cycle
- alu_zero  in  1  ALU result == 0
- alu_lsb  in  1  ALU result bit 0 (SLT/SLTU outcome)
- mem_req  out  1  memory request
- mem_we  out  1  store when 1
- ir_write  out  1  load IR and old_pc
- pc_write  out  1  load PC
- pc_src  out  1  0 = ALU result (combinational), 1 = alu_out register
- reg_write  out  1  register file write
- wb_sel  out  2  0 = alu_out, 1 = mem data, 2 = PC
- alu_src_a  out  2  0 = rs1, 1 = PC, 2 = old_pc, 3 = zero
- alu_src_b  out  2  0 = rs2, 1 = imm, 2 = const 4
- imm_sel  out  3  0 = I, 1 = S, 2 = B, 3 = U, 4 = J
- alu_control  out  ALU_CTRL_W  ALU operation
- illegal  out  1  sticky illegal-instruction trap
- bus_err  out  1  sticky memory timeout trap
- state  out  3  FSM state, for debug

## Operation
- alu_control encoding: {b3, func3}; ADD=0000, SUB=1000, SLL=0001, SLT=0010, SLTU=0011, XOR=0100, SRL=0101, SRA=1101, OR=0110, AND=0111.
- b3 = instr[30] for OP (func3 000/101) and for OP-IMM (func3 101 only). ADDI never subtracts.
- Default outputs in every state unless listed: all enables 0, alu_control ADD, all selects 0.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- FETCH
  - Outputs: mem_req=1; a=PC, b=4, ADD.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, go to DECODE. Otherwise stay.
- DECODE
  - Outputs: a=old_pc, b=imm (B for BRANCH, J for JAL), ADD. This precomputes the branch/jump target into alu_out.
  - Illegal encoding → TRAP. Illegal means any of:
    - unknown opcode;
    - OP with func7 ∉ {0000000, 0100000}, or 0100000 with func3 ∉ {000, 101};
    - OP-IMM shift with a bad func7;
    - BRANCH func3 010/011;
    - LOAD func3 011/110/111;
    - STORE func3 >010;
    - JALR func3 ≠000.
  - Otherwise → EXEC.
- EXEC
  - OP: a=rs1, b=rs2 → WB.
  - OP-IMM: a=rs1, b=imm(I) → WB.
  - LUI: a=zero, b=imm(U) → WB.
  - AUIPC: a=old_pc, b=imm(U) → WB.
  - LOAD/STORE: a=rs1, b=imm (I or S), ADD → MEM.
  - BRANCH: a=rs1, b=rs2. Operation: SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU.
    - Taken conditions: BEQ alu_zero; BNE !alu_zero; BLT/BLTU alu_lsb; BGE/BGEU !alu_lsb.
    - If taken: pc_write=1, pc_src=1. Always → FETCH.
  - JAL: pc_write=1, pc_src=1, reg_write=1, wb_sel=2 → FETCH.
  - JALR: a=rs1, b=imm(I), ADD, pc_write=1, pc_src=0, reg_write=1, wb_sel=2 → FETCH. The datapath clears bit 0.
- MEM
  - Outputs: mem_req=1, mem_we=1 for STORE.
  - On mem_ready: STORE → FETCH, LOAD → WB. Otherwise hold.
- WB: reg_write=1, wb_sel=1 for LOAD else 0 → FETCH.
- TRAP: all enables 0; illegal or bus_err held at 1; exits only on rst.
- Timeout: a counter is cleared on entering FETCH or MEM.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT without mem_ready → TRAP, bus_err=1.
  - mem_ready on the same cycle as the limit wins.

## Timing
- All outputs are combinational from the state register, instr and flags. State, counter and trap flags are registered.
- Reset state: FETCH. First cycle after rst: mem_req=1, all other enables 0, illegal=0, bus_err=0, state=0.
- rst asserted in any state, including mid-request or TRAP, returns to FETCH on that edge.
- Cycles with zero-wait memory:
  - branch/JAL/JALR: 3
  - ALU/LUI/AUIPC/store: 4
  - load: 5
- Each wait cycle adds 1 cycle.
- mem_req stays high and stable until mem_ready. No request is issued in DECODE, EXEC, WB or TRAP.

## Test plan
- ADD x3,x1,x2 (0x002081B3), mem_ready always 1 → states 0,1,2,4; reg_write only in the WB cycle with wb_sel=0; alu_control 0000 in EXEC.
- SUB (0x402081B3), then SRAI (0x4020D193) → alu_control 1000 and 1101. ADDI with instr[30]=1 (0x40008193) → 0000.
- BEQ with alu_zero=1 → pc_write=1, pc_src=1 in EXEC; with alu_zero=0 → pc_write=0; both return to FETCH after 3 cycles.
- LW with mem_ready low for 3 cycles in MEM → mem_req held 4 cycles, then WB with wb_sel=1; total 8 cycles.
- Opcode 0x7F, or OP with func7=0x01 → TRAP at the DECODE edge, illegal=1 persists; rst → FETCH, illegal=0.
- MEM_TIMEOUT=4, mem_ready never asserted → bus_err=1 after 4 FETCH cycles. Repeat with mem_ready on the 4th cycle → no trap.
